// File: rtl/bmp_rx_pkg.sv
// ---------------------------------------------------------------------------
// bmp_rx_pkg
// Shared types and constants for the BMP byte-stream receiver: FSM state
// encoding, header field byte positions, file signature and the supported
// bit depths.
// ---------------------------------------------------------------------------
package bmp_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SKIP,
    S_PIX,
    S_PAD,
    S_ERR
  } state_t;

  // Byte positions of little-endian header fields within the file.
  localparam logic [31:0] OFS_OFFSET   = 32'd10;
  localparam logic [31:0] OFS_WIDTH    = 32'd18;
  localparam logic [31:0] OFS_HEIGHT   = 32'd22;
  localparam logic [31:0] OFS_BITCOUNT = 32'd28;
  localparam logic [31:0] OFS_COMPRESS = 32'd30;
  localparam logic [31:0] HDR_LEN      = 32'd54;

  localparam logic [7:0]  SIG_B = 8'h42;
  localparam logic [7:0]  SIG_M = 8'h4D;

  localparam logic [15:0] BC_8  = 16'd8;
  localparam logic [15:0] BC_24 = 16'd24;

  // True when byte index cnt falls inside the field [base, base+len).
  function automatic logic in_field(input logic [31:0] cnt,
                                    input logic [31:0] base,
                                    input int unsigned len);
    return (cnt >= base) && (cnt < base + len);
  endfunction

endpackage

// File: rtl/bmp_stream_rx.sv
// ---------------------------------------------------------------------------
// bmp_stream_rx
// Parses an uncompressed 8-bit or 24-bit BMP file arriving one byte per
// handshake and emits one pixel per output handshake in file order.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_data/s_valid/s_ready     file byte stream in
//   m_data/m_valid/m_ready     pixel out: {R,G,B} or {16'h0, index}
//   m_sof/m_eol/m_eof          first pixel / row end / last pixel markers
//   img_w/img_h/img_bc         decoded header fields, valid with hdr_ok
//   hdr_ok, err                header accepted / sticky format error
//   clr                        synchronous abort: back to IDLE, err cleared
// ---------------------------------------------------------------------------
module bmp_stream_rx
  import bmp_rx_pkg::*;
#(
  parameter int unsigned MAX_W = 4096,
  parameter int unsigned MAX_H = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [23:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof,
  output logic [15:0] img_w,
  output logic [15:0] img_h,
  output logic [7:0]  img_bc,
  output logic        hdr_ok,
  output logic        err,
  input  logic        clr
);

  state_t      state, state_nxt;
  logic        run;
  logic [31:0] byte_cnt, offset, width, height, comp;
  logic [15:0] bitcount, x_cnt, y_cnt;
  logic [1:0]  phase, pad_cnt;
  logic [7:0]  b_byte, g_byte;

  logic        accept, is24, pix_done, last_col, last_row, row_end, hdr_bad;
  logic [1:0]  row_pad;

  // Row padding to a 4-byte boundary. Only width mod 4 matters: 8-bit rows
  // are width bytes, 24-bit rows are 3*width bytes.
  function automatic logic [1:0] pad_of(input logic [1:0] w, input logic wide);
    logic [1:0] rb;
    rb = wide ? w * 2'd3 : w;
    return 2'd0 - rb;
  endfunction

  // run holds s_ready low until the first edge after reset release.
  assign s_ready  = run && ((state != S_PIX) || !m_valid || m_ready);
  assign accept   = s_valid && s_ready;
  assign is24     = (bitcount == BC_24);
  assign pix_done = accept && (state == S_PIX) && (!is24 || phase == 2'd2);
  assign last_col = (x_cnt == width[15:0] - 16'd1);
  assign last_row = (y_cnt == height[15:0] - 16'd1);
  assign row_end  = pix_done && last_col;
  assign row_pad  = pad_of(width[1:0], is24);

  assign hdr_bad = ((bitcount != BC_8) && (bitcount != BC_24)) ||
                   (comp != '0) ||
                   (width == '0) || (width > MAX_W) ||
                   ($signed(height) <= 0) || ($signed(height) > $signed(MAX_H)) ||
                   (offset < HDR_LEN);

  assign img_w  = width[15:0];
  assign img_h  = height[15:0];
  assign img_bc = bitcount[7:0];

  // NOTE: every flop is written with <= so all reads within an edge see the
  // pre-edge value, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // NOTE: state_nxt gets its default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = (s_data == SIG_B) ? S_HDR : S_ERR;
      S_HDR: begin
        if (accept) begin
          if (byte_cnt == 32'd1 && s_data != SIG_M) begin
            state_nxt = S_ERR;
          end else if (byte_cnt == HDR_LEN - 32'd1) begin
            if (hdr_bad)                state_nxt = S_ERR;
            else if (offset == HDR_LEN) state_nxt = S_PIX;
            else                        state_nxt = S_SKIP;
          end
        end
      end
      S_SKIP: if (accept && byte_cnt == offset - 32'd1) state_nxt = S_PIX;
      S_PIX: begin
        if (row_end) begin
          if (row_pad != 2'd0) state_nxt = S_PAD;
          else if (last_row)   state_nxt = S_IDLE;
        end
      end
      // y_cnt has already advanced past the row whose padding is draining.
      S_PAD: if (accept && pad_cnt == 2'd1)
               state_nxt = (y_cnt == height[15:0]) ? S_IDLE : S_PIX;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
    if (clr) state_nxt = S_IDLE;
  end

  // NOTE: every register, datapath included, is cleared by reset so outputs
  // and counters are defined from the first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_sof    <= 1'b0;
      m_eol    <= 1'b0;
      m_eof    <= 1'b0;
      hdr_ok   <= 1'b0;
      err      <= 1'b0;
      byte_cnt <= '0;
      offset   <= '0;
      width    <= '0;
      height   <= '0;
      comp     <= '0;
      bitcount <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      phase    <= '0;
      pad_cnt  <= '0;
      b_byte   <= '0;
      g_byte   <= '0;
    end else if (clr) begin
      m_valid  <= 1'b0;
      m_sof    <= 1'b0;
      m_eol    <= 1'b0;
      m_eof    <= 1'b0;
      hdr_ok   <= 1'b0;
      err      <= 1'b0;
      byte_cnt <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      phase    <= '0;
      pad_cnt  <= '0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (accept && byte_cnt != '1) byte_cnt <= byte_cnt + 32'd1;

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            byte_cnt <= 32'd1;
            x_cnt    <= '0;
            y_cnt    <= '0;
            phase    <= '0;
            if (s_data != SIG_B) begin
              err     <= 1'b1;
              m_valid <= 1'b0;
            end
          end
        end
        S_HDR: begin
          if (accept) begin
            // Little-endian fields: shift each byte in from the top.
            if (in_field(byte_cnt, OFS_OFFSET, 4))   offset   <= {s_data, offset[31:8]};
            if (in_field(byte_cnt, OFS_WIDTH, 4))    width    <= {s_data, width[31:8]};
            if (in_field(byte_cnt, OFS_HEIGHT, 4))   height   <= {s_data, height[31:8]};
            if (in_field(byte_cnt, OFS_BITCOUNT, 2)) bitcount <= {s_data, bitcount[15:8]};
            if (in_field(byte_cnt, OFS_COMPRESS, 4)) comp     <= {s_data, comp[31:8]};
            if (byte_cnt == 32'd1 && s_data != SIG_M) begin
              err     <= 1'b1;
              m_valid <= 1'b0;
            end
            if (byte_cnt == HDR_LEN - 32'd1) begin
              if (hdr_bad) begin
                err     <= 1'b1;
                m_valid <= 1'b0;
              end else begin
                hdr_ok  <= 1'b1;
              end
            end
          end
        end
        S_PIX: begin
          if (pix_done) begin
            m_valid <= 1'b1;
            m_data  <= is24 ? {s_data, g_byte, b_byte} : {16'h0, s_data};
            m_sof   <= (x_cnt == '0) && (y_cnt == '0);
            m_eol   <= last_col;
            m_eof   <= last_col && last_row;
            phase   <= '0;
            if (last_col) begin
              x_cnt   <= '0;
              y_cnt   <= y_cnt + 16'd1;
              pad_cnt <= row_pad;
              if (row_pad == 2'd0 && last_row) hdr_ok <= 1'b0;
            end else begin
              x_cnt   <= x_cnt + 16'd1;
            end
          end else if (accept) begin
            if (phase == 2'd0) b_byte <= s_data;
            else               g_byte <= s_data;
            phase <= phase + 2'd1;
          end
        end
        S_PAD: begin
          if (accept) begin
            pad_cnt <= pad_cnt - 2'd1;
            if (pad_cnt == 2'd1 && y_cnt == height[15:0]) hdr_ok <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
